// File: rtl/sop_pkg.sv
// Shared definitions for the 4-tap sum-of-products datapath and its output FIFO.
package sop_pkg;

  localparam int SOP_SIZE  = 4;
  localparam int SOP_DEPTH = 8;

  // A product of two SIZE-bit values plus four accumulated taps needs 2*SIZE+2 bits.
  function automatic int sop_w(input int size);
    return 2 * size + 2;
  endfunction

  localparam int SOP_W = sop_w(SOP_SIZE);

  typedef logic [SOP_W-1:0] sop_word_t;

endpackage

// File: rtl/sop_fifo_mem.sv
// DEPTH x W register array: synchronous write, asynchronous read, storage never reset.
module sop_fifo_mem #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sop_out_fifo.sv
// First-word-fall-through output FIFO for SOP results with sticky overflow flag.
// Optional peak tracking is enabled by defining SOP_PEAK_TRACK_EN.
module sop_out_fifo
  import sop_pkg::*;
#(
  parameter int SIZE  = SOP_SIZE,
  parameter int DEPTH = SOP_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [sop_w(SIZE)-1:0] DIN,
  input  logic                   DIN_VLD,
  output logic [sop_w(SIZE)-1:0] DOUT,
  output logic                   DOUT_VLD,
  input  logic                   DOUT_RDY,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [AW:0]            COUNT,
  output logic                   OVF,
  input  logic                   OVF_CLR,
  output logic [sop_w(SIZE)-1:0] PEAK,
  input  logic                   PEAK_CLR
);

  localparam int W = sop_w(SIZE);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [W-1:0]  rd_data;
  logic          push;
  logic          pop;
  logic          drop;

  // Flags come only from the registered count so they never see the handshake inputs.
  assign EMPTY    = (count == '0);
  assign FULL     = (count == (AW+1)'(DEPTH));
  assign DOUT_VLD = !EMPTY;
  assign COUNT    = count;
  assign OVF      = ovf;

  assign pop  = DOUT_VLD & DOUT_RDY;
  assign push = DIN_VLD & (!FULL | pop);
  assign drop = DIN_VLD & FULL & !pop;

  sop_fifo_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (DIN),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign DOUT = EMPTY ? '0 : rd_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set so no event is lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (OVF_CLR) ovf <= 1'b0;
  end

`ifdef SOP_PEAK_TRACK_EN
  logic [W-1:0] peak;

  // A clear coinciding with a push restarts tracking from that pushed word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                peak <= '0;
    else if (push && (PEAK_CLR || DIN > peak)) peak <= DIN;
    else if (PEAK_CLR)                      peak <= '0;
  end

  assign PEAK = peak;
`else
  logic unused_peak_clr;

  assign unused_peak_clr = PEAK_CLR;
  assign PEAK            = '0;
`endif

endmodule

// File: tb/tb_sop_out_fifo.sv
// Scoreboard bench for sop_out_fifo: directed pushes queue expected words, a monitor checks pops.
module tb_sop_out_fifo;

  localparam int W  = 10;
  localparam int AW = 3;

  logic          CLK;
  logic          RST;
  logic [W-1:0]  DIN;
  logic          DIN_VLD;
  logic [W-1:0]  DOUT;
  logic          DOUT_VLD;
  logic          DOUT_RDY;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   COUNT;
  logic          OVF;
  logic          OVF_CLR;
  logic [W-1:0]  PEAK;
  logic          PEAK_CLR;

  logic [W-1:0] sb [$];
  int n_cmp  = 0;
  int n_fail = 0;

  sop_out_fifo #(
    .SIZE  (4),
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIN      (DIN),
    .DIN_VLD  (DIN_VLD),
    .DOUT     (DOUT),
    .DOUT_VLD (DOUT_VLD),
    .DOUT_RDY (DOUT_RDY),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .COUNT    (COUNT),
    .OVF      (OVF),
    .OVF_CLR  (OVF_CLR),
    .PEAK     (PEAK),
    .PEAK_CLR (PEAK_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, then return inputs to idle.
  task automatic applyStimulus(input logic [W-1:0] din, input logic vld, input logic rdy,
                               input logic oclr, input logic pclr);
    DIN      = din;
    DIN_VLD  = vld;
    DOUT_RDY = rdy;
    OVF_CLR  = oclr;
    PEAK_CLR = pclr;
    @(posedge CLK);
    #1;
    DIN_VLD  = 1'b0;
    DOUT_RDY = 1'b0;
    OVF_CLR  = 1'b0;
    PEAK_CLR = 1'b0;
  endtask

  task automatic drainAll();
    int budget;
    budget = 40;
    while (sb.size() > 0 && budget > 0) begin
      applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0);
      budget--;
    end
    checkOutput("drain_timeout_left", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every accepted head word must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST && DOUT_VLD && DOUT_RDY) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL dout_unexpected: got 0x%0h expected no output", DOUT);
      end else begin
        checkOutput("dout_order", 32'(DOUT), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1; DIN = '0; DIN_VLD = 1'b0; DOUT_RDY = 1'b0; OVF_CLR = 1'b0; PEAK_CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_count", 32'(COUNT), 32'd0);
    checkOutput("rst_empty", 32'(EMPTY), 32'd1);
    checkOutput("rst_full", 32'(FULL), 32'd0);
    checkOutput("rst_dout_vld", 32'(DOUT_VLD), 32'd0);
    checkOutput("rst_dout", 32'(DOUT), 32'd0);
    checkOutput("rst_ovf", 32'(OVF), 32'd0);
    checkOutput("rst_peak", 32'(PEAK), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Fill with 1..8, consumer stalled.
    for (int i = 1; i <= 8; i++) begin
      sb.push_back(W'(i));
      applyStimulus(W'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 1) begin
        checkOutput("fwft_vld", 32'(DOUT_VLD), 32'd1);
        checkOutput("fwft_dout", 32'(DOUT), 32'h001);
      end
    end
    checkOutput("fill_full", 32'(FULL), 32'd1);
    checkOutput("fill_count", 32'(COUNT), 32'd8);
    checkOutput("fill_head", 32'(DOUT), 32'h001);

    // Overflow: dropped word, sticky flag, set beats clear.
    applyStimulus(10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_set", 32'(OVF), 32'd1);
    checkOutput("ovf_count", 32'(COUNT), 32'd8);
    checkOutput("ovf_head", 32'(DOUT), 32'h001);
    applyStimulus(10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_set_priority", 32'(OVF), 32'd1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_clr", 32'(OVF), 32'd0);

    // Full with simultaneous push and pop: no drop.
    sb.push_back(10'h155);
    applyStimulus(10'h155, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("fullpp_count", 32'(COUNT), 32'd8);
    checkOutput("fullpp_ovf", 32'(OVF), 32'd0);
    drainAll();
    checkOutput("drain_empty", 32'(EMPTY), 32'd1);
    checkOutput("drain_dout", 32'(DOUT), 32'd0);

    // Empty with valid and ready: push only.
    sb.push_back(10'h0AA);
    applyStimulus(10'h0AA, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("emptypr_count", 32'(COUNT), 32'd1);
    checkOutput("emptypr_dout", 32'(DOUT), 32'h0AA);
    drainAll();

    // Continuous streaming across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      if (i > 0) checkOutput("wrap_no_gap", 32'(DOUT_VLD), 32'd1);
      sb.push_back(W'(i));
      applyStimulus(W'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("wrap_count", 32'(COUNT), 32'd1);
    drainAll();
    checkOutput("wrap_empty", 32'(EMPTY), 32'd1);

    // Peak tracking.
`ifdef SOP_PEAK_TRACK_EN
    checkOutput("peak_hist", 32'(PEAK), 32'h155);
`else
    checkOutput("peak_hist", 32'(PEAK), 32'h000);
`endif
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("peak_clr", 32'(PEAK), 32'h000);
    sb.push_back(10'h010);
    applyStimulus(10'h010, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(10'h2A0);
    applyStimulus(10'h2A0, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(10'h050);
    applyStimulus(10'h050, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SOP_PEAK_TRACK_EN
    checkOutput("peak_max", 32'(PEAK), 32'h2A0);
`else
    checkOutput("peak_max", 32'(PEAK), 32'h000);
`endif
    sb.push_back(10'h005);
    applyStimulus(10'h005, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef SOP_PEAK_TRACK_EN
    checkOutput("peak_clr_push", 32'(PEAK), 32'h005);
`else
    checkOutput("peak_clr_push", 32'(PEAK), 32'h000);
`endif
    checkOutput("peak_pp_count", 32'(COUNT), 32'd3);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("peak_clr2", 32'(PEAK), 32'h000);

    // Asynchronous reset mid-cycle with three entries held.
    checkOutput("pre_rst_count", 32'(COUNT), 32'd3);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("arst_count", 32'(COUNT), 32'd0);
    checkOutput("arst_empty", 32'(EMPTY), 32'd1);
    checkOutput("arst_dout", 32'(DOUT), 32'd0);
    checkOutput("arst_ovf", 32'(OVF), 32'd0);
    sb.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_count", 32'(COUNT), 32'd0);
    checkOutput("sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
